ps2_arrow_ctrl: RTL and testbench
=================================

PS2_ARROW_CTRL -- requirements
Module: ps2_arrow_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_PIXELS, 640, visible width.
- V_PIXELS, 480, visible height.
- SQUARE_SIZE, 10, sprite half-size and edge margin.
- INIT_X, 320, reset X.
- INIT_Y, 240, reset Y.
- RX_TIMEOUT, 25000, vga_clk cycles without a ps2_clk falling edge before frame abort.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- vga_clk  in  1  25 MHz pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- sq_pos_x  out  10  sprite centre X.
- sq_pos_y  out  10  sprite centre Y.
- dir  out  4  held-direction flags {up, down, left, right}.
- key_valid  out  1  one-cycle pulse per decoded arrow event.
- key_code  out  8  scan code of the last arrow event.
- key_break  out  1  1 = last event was a release.
- rx_err  out  1  one-cycle pulse on a receive error.

Function
REQ-003 ps2_clk and ps2_data SHALL pass through 2-flop synchronisers; data SHALL be sampled on the falling edge of synchronised ps2_clk.
REQ-004 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE->DATA on a falling edge with data=0 (start bit); a falling edge with data=1 stays in IDLE, no error.
- DATA shifts 8 bits, LSB first, then ->PARITY.
- PARITY checks odd parity over data+parity, then ->STOP.
REQ-005 At STOP: stop bit=1 with good parity SHALL complete the byte; bad parity or stop=0 SHALL pulse rx_err, discard the byte and return to IDLE.
REQ-006 If no falling edge occurs for RX_TIMEOUT cycles outside IDLE, the FSM SHALL return to IDLE and pulse rx_err.
REQ-007 Decoder flags ext and brk SHALL be handled per completed byte:
- 0xE0 sets ext.
- 0xF0 sets brk.
- Any other byte clears both after processing.
REQ-008 With ext set, codes 0x75/0x72/0x6B/0x74 (up/down/left/right) SHALL produce an event:
- key_valid pulses one cycle after the STOP-bit edge is detected, with key_code and key_break valid in that cycle.
- dir updates in the same cycle as key_valid.
REQ-009 Event effect on dir:
- Make sets that direction bit and clears the opposite bit on the same axis; the other axis is unaffected.
- Break clears that direction bit only.
- Non-extended codes and other extended codes produce no event and do not change dir.
REQ-010 On frame_tick, each axis SHALL move at most 1 pixel using the dir value present before any same-cycle key event.
- up decrements Y, down increments Y; left decrements X, right increments X.
- The result updates the cycle after frame_tick.
REQ-011 Positions SHALL saturate with no wrap: Y in [SQUARE_SIZE, V_PIXELS-1-SQUARE_SIZE] = [10,469], X in [SQUARE_SIZE, H_PIXELS-1-SQUARE_SIZE] = [10,629]; a move at a limit is suppressed and dir is kept.
REQ-012 A byte completion and a frame_tick in the same cycle SHALL both be serviced; neither is dropped.

Reset
REQ-013 While reset_n=0, all state SHALL clear asynchronously:
- FSM to IDLE; ext=brk=0.
- sq_pos_x=INIT_X, sq_pos_y=INIT_Y.
- dir=0, key_valid=0, key_code=0, key_break=0, rx_err=0.
- Synchronisers to 1 (bus idle).
REQ-014 Reset asserted mid-frame SHALL discard the partial byte; the first frame after release begins at a new start bit.

Structure
REQ-015 Package ps2_pkg SHALL hold the scan-code constants (E0, F0, 75, 72, 6B, 74), the receiver state enum and the RX_TIMEOUT default.
REQ-016 Sub-module ps2_rx SHALL contain the synchronisers, receiver FSM, parity check and timeout, and output a byte, a byte-valid pulse and an error pulse; ps2_arrow_ctrl holds the decoder and the motion logic.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Frames E0,75 then 5 frame_ticks -> key_valid once with key_code=0x75, key_break=0; dir=1000; Y=235, X=320.
- Hold up, then E0,72 -> dir=0100; 3 ticks -> Y rises by 3.
- E0,F0,6B after left make -> key_break=1, dir=0000; further ticks leave X unchanged.
- Frame for 0x74 with parity flipped -> rx_err pulse, no key_valid, dir unchanged.
- ps2_clk stalls after 4 data bits for 25001 cycles -> rx_err pulse; next valid E0,74 decodes normally.
- Left held from X=320 for 400 ticks -> X stops at 10; reset_n low mid-frame -> X=320, Y=240, dir=0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan codes, receiver state encoding and defaults for the PS/2 arrow-key sprite controller.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int RX_TIMEOUT_DEF = 25000;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // One-hot position in the {up, down, left, right} direction vector; zero for non-arrow codes.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    case (code)
      SC_UP:    return 4'b1000;
      SC_DOWN:  return 4'b0100;
      SC_LEFT:  return 4'b0010;
      SC_RIGHT: return 4'b0001;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_arrow_ctrl_if.sv
// Signal bundle between the PS/2 arrow controller and its environment.
interface ps2_arrow_ctrl_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       frame_tick;
  logic [9:0] sq_pos_x;
  logic [9:0] sq_pos_y;
  logic [3:0] dir;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       rx_err;

  modport master (
    output ps2_clk, ps2_data, frame_tick,
    input  sq_pos_x, sq_pos_y, dir, key_valid, key_code, key_break, rx_err
  );

  modport slave (
    input  ps2_clk, ps2_data, frame_tick,
    output sq_pos_x, sq_pos_y, dir, key_valid, key_code, key_break, rx_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronisers, start/data/parity/stop FSM and an inter-edge timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int RX_TIMEOUT = RX_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       rx_err
);

  localparam int               TMO_W    = $clog2(RX_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RX_TIMEOUT - 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_prev_q;
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             fall, din, timeout;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign din     = dat_sync_q[1];
  assign timeout = (state_q != RX_IDLE) && !fall && (tmo_cnt_q == TMO_LAST);

  // Synchronisers reset to 1 so a released bus never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_ok_q   <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (fall && !din) state_d = RX_DATA;
      RX_DATA:   if (fall && bit_cnt_q == 3'd7) state_d = RX_PARITY;
      RX_PARITY: if (fall) state_d = RX_STOP;
      RX_STOP:   if (fall) state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
    if (timeout) state_d = RX_IDLE;
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_ok_d  = par_ok_q;
    tmo_cnt_d = (state_q == RX_IDLE || fall) ? '0 : tmo_cnt_q + 1'b1;
    if (state_q == RX_IDLE) bit_cnt_d = 3'd0;
    if (fall && state_q == RX_DATA) begin
      shift_d   = {din, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    if (fall && state_q == RX_PARITY) par_ok_d = ^{shift_q, din};
  end

  always_comb begin
    rx_byte_vld = 1'b0;
    rx_err      = timeout;
    if (state_q == RX_STOP && fall) begin
      if (din && par_ok_q) rx_byte_vld = 1'b1;
      else                 rx_err      = 1'b1;
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_arrow_ctrl.sv
// Arrow-key sprite controller: decodes extended PS/2 arrow make/break codes into held
// directions and moves a saturating sprite position by one pixel per video frame.
module ps2_arrow_ctrl
  import ps2_pkg::*;
#(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int SQUARE_SIZE = 10,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int RX_TIMEOUT  = RX_TIMEOUT_DEF
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  ps2_arrow_ctrl_if.slave bus
);

  localparam logic [9:0] X_MIN  = 10'(SQUARE_SIZE);
  localparam logic [9:0] X_MAX  = 10'(H_PIXELS - 1 - SQUARE_SIZE);
  localparam logic [9:0] Y_MIN  = 10'(SQUARE_SIZE);
  localparam logic [9:0] Y_MAX  = 10'(V_PIXELS - 1 - SQUARE_SIZE);
  localparam logic [9:0] X_INIT = 10'(INIT_X);
  localparam logic [9:0] Y_INIT = 10'(INIT_Y);

  logic [7:0] rx_byte;
  logic       rx_byte_vld, rx_err_p;

  ps2_rx #(.RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clk         (vga_clk),
    .reset_n     (reset_n),
    .ps2_clk     (bus.ps2_clk),
    .ps2_data    (bus.ps2_data),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld),
    .rx_err      (rx_err_p)
  );

  logic       ext_q, ext_d, brk_q, brk_d;
  logic [3:0] dir_q, dir_d;
  logic       key_valid_q, key_valid_d, key_break_q, key_break_d;
  logic [7:0] key_code_q, key_code_d;
  logic       rx_err_q, rx_err_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] mask, opposite;

  assign mask     = arrow_mask(rx_byte);
  assign opposite = {mask[2], mask[3], mask[0], mask[1]};

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      dir_q       <= 4'b0000;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_break_q <= 1'b0;
      rx_err_q    <= 1'b0;
      x_q         <= X_INIT;
      y_q         <= Y_INIT;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      dir_q       <= dir_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_break_q <= key_break_d;
      rx_err_q    <= rx_err_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    dir_d       = dir_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_break_d = key_break_q;
    rx_err_d    = rx_err_p;
    if (rx_byte_vld) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q && mask != 4'b0000) begin
          key_valid_d = 1'b1;
          key_code_d  = rx_byte;
          key_break_d = brk_q;
          dir_d       = brk_q ? (dir_q & ~mask) : ((dir_q & ~opposite) | mask);
        end
      end
    end
  end

  // Motion uses the registered dir, so a key event in the tick cycle only affects later frames.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.frame_tick) begin
      if (dir_q[3] && y_q > Y_MIN)      y_d = y_q - 10'd1;
      else if (dir_q[2] && y_q < Y_MAX) y_d = y_q + 10'd1;
      if (dir_q[1] && x_q > X_MIN)      x_d = x_q - 10'd1;
      else if (dir_q[0] && x_q < X_MAX) x_d = x_q + 10'd1;
    end
  end

  assign bus.sq_pos_x  = x_q;
  assign bus.sq_pos_y  = y_q;
  assign bus.dir       = dir_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_break = key_break_q;
  assign bus.rx_err    = rx_err_q;

endmodule

// File: tb/tb_ps2_arrow_ctrl.sv
// Self-checking bench for ps2_arrow_ctrl: directed PS/2 scenarios plus a randomized key/tick stream.
`timescale 1ns/1ps
module tb_ps2_arrow_ctrl;
  import ps2_pkg::*;

  localparam int HB = 8;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  ps2_arrow_ctrl_if bus();

  ps2_arrow_ctrl dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #20 vga_clk = ~vga_clk;

  int vectors = 0;
  int miscompares = 0;

  int         kv_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] kv_code = 8'h00;
  logic       kv_brk = 1'b0;
  logic [9:0] kv_y = 10'd0;
  bit         b2b_en = 0;
  bit         b2b_arm = 0;
  int         b2b_cnt = 0;

  int  m_x, m_y;
  int  m_ev = 0;
  bit  m_up, m_down, m_left, m_right, m_ext, m_brk;

  always @(negedge vga_clk) begin
    if (reset_n) begin
      if (bus.key_valid === 1'b1) begin
        kv_cnt++;
        kv_code = bus.key_code;
        kv_brk  = bus.key_break;
        kv_y    = bus.sq_pos_y;
        if (b2b_en) b2b_arm = 1;
      end
      if (bus.rx_err === 1'b1) err_cnt++;
    end
  end

  always @(posedge vga_clk) begin
    if (b2b_arm && bus.frame_tick === 1'b1) b2b_cnt++;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] m_dir();
    return {m_up, m_down, m_left, m_right};
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240;
    m_up = 0; m_down = 0; m_left = 0; m_right = 0;
    m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_ext && (b == 8'h75 || b == 8'h72 || b == 8'h6B || b == 8'h74)) begin
        m_ev++;
        if (b == 8'h75) begin if (m_brk) m_up = 0;    else begin m_up = 1;    m_down = 0;  end end
        if (b == 8'h72) begin if (m_brk) m_down = 0;  else begin m_down = 1;  m_up = 0;    end end
        if (b == 8'h6B) begin if (m_brk) m_left = 0;  else begin m_left = 1;  m_right = 0; end end
        if (b == 8'h74) begin if (m_brk) m_right = 0; else begin m_right = 1; m_left = 0;  end end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_tick();
    if (m_up && m_y > 10) m_y = m_y - 1;
    if (m_down && m_y < 469) m_y = m_y + 1;
    if (m_left && m_x > 10) m_x = m_x - 1;
    if (m_right && m_x < 629) m_x = m_x + 1;
  endtask

  task automatic drive_bit(input logic v);
    bus.ps2_data = v;
    repeat (HB) @(negedge vga_clk);
    bus.ps2_clk = 1'b0;
    repeat (HB) @(negedge vga_clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(f[i]);
    bus.ps2_data = 1'b1;
    repeat (10) @(negedge vga_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk) bus.frame_tick = 1'b1;
      @(negedge vga_clk) bus.frame_tick = 1'b0;
      model_tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge vga_clk);
    vectors++; if (bus.sq_pos_x !== 10'd320) begin miscompares++; $display("FAIL reset_x: got %0d want 320", bus.sq_pos_x); end
    vectors++; if (bus.sq_pos_y !== 10'd240) begin miscompares++; $display("FAIL reset_y: got %0d want 240", bus.sq_pos_y); end
    vectors++; if (bus.dir !== 4'b0000) begin miscompares++; $display("FAIL reset_dir: got %b want 0000", bus.dir); end
    vectors++; if (bus.key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid: got %b want 0", bus.key_valid); end
    vectors++; if (bus.key_code !== 8'h00) begin miscompares++; $display("FAIL reset_key_code: got %h want 00", bus.key_code); end
    vectors++; if (bus.key_break !== 1'b0) begin miscompares++; $display("FAIL reset_key_break: got %b want 0", bus.key_break); end
    vectors++; if (bus.rx_err !== 1'b0) begin miscompares++; $display("FAIL reset_rx_err: got %b want 0", bus.rx_err); end
  endtask

  task automatic test_up_make();
    send_byte(8'hE0);
    send_byte(8'h75);
    ticks(5);
    vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL up_kv_count: got %0d want %0d", kv_cnt, m_ev); end
    vectors++; if (kv_code !== 8'h75) begin miscompares++; $display("FAIL up_key_code: got %h want 75", kv_code); end
    vectors++; if (kv_brk !== 1'b0) begin miscompares++; $display("FAIL up_key_break: got %b want 0", kv_brk); end
    vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL up_dir: got %b want %b", bus.dir, m_dir()); end
    vectors++; if (bus.sq_pos_y !== 10'(m_y)) begin miscompares++; $display("FAIL up_y: got %0d want %0d", bus.sq_pos_y, m_y); end
    vectors++; if (bus.sq_pos_x !== 10'(m_x)) begin miscompares++; $display("FAIL up_x: got %0d want %0d", bus.sq_pos_x, m_x); end
  endtask

  task automatic test_reverse();
    send_byte(8'hE0);
    send_byte(8'h72);
    vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL rev_dir: got %b want %b", bus.dir, m_dir()); end
    ticks(3);
    vectors++; if (bus.sq_pos_y !== 10'(m_y)) begin miscompares++; $display("FAIL rev_y: got %0d want %0d", bus.sq_pos_y, m_y); end
  endtask

  task automatic test_left_break();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'h6B);
    ticks(2);
    vectors++; if (bus.sq_pos_x !== 10'(m_x)) begin miscompares++; $display("FAIL left_x: got %0d want %0d", bus.sq_pos_x, m_x); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    vectors++; if (kv_brk !== 1'b1) begin miscompares++; $display("FAIL brk_key_break: got %b want 1", kv_brk); end
    vectors++; if (kv_code !== 8'h6B) begin miscompares++; $display("FAIL brk_key_code: got %h want 6b", kv_code); end
    vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL brk_dir: got %b want %b", bus.dir, m_dir()); end
    ticks(4);
    vectors++; if (bus.sq_pos_x !== 10'(m_x)) begin miscompares++; $display("FAIL brk_x: got %0d want %0d", bus.sq_pos_x, m_x); end
    vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL brk_kv_count: got %0d want %0d", kv_cnt, m_ev); end
  endtask

  task automatic test_parity_err();
    int e0;
    send_byte(8'hE0);
    e0 = err_cnt;
    send_frame(8'h74, 1'b1);
    vectors++; if (err_cnt !== e0 + 1) begin miscompares++; $display("FAIL par_rx_err: got %0d pulses want 1", err_cnt - e0); end
    vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL par_kv_count: got %0d want %0d", kv_cnt, m_ev); end
    vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL par_dir: got %b want %b", bus.dir, m_dir()); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
    bus.ps2_data = 1'b1;
    repeat (25001) @(negedge vga_clk);
    vectors++; if (err_cnt !== e0 + 1) begin miscompares++; $display("FAIL tmo_rx_err: got %0d pulses want 1", err_cnt - e0); end
    send_byte(8'hE0);
    send_byte(8'h74);
    vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL tmo_kv_count: got %0d want %0d", kv_cnt, m_ev); end
    vectors++; if (kv_code !== 8'h74) begin miscompares++; $display("FAIL tmo_key_code: got %h want 74", kv_code); end
    vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL tmo_dir: got %b want %b", bus.dir, m_dir()); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
  endtask

  task automatic test_back_to_back();
    int y0;
    vectors++; if (bus.dir !== 4'b0000) begin miscompares++; $display("FAIL b2b_start_dir: got %b want 0000", bus.dir); end
    y0 = m_y;
    send_byte(8'hE0);
    b2b_cnt = 0;
    b2b_en = 1;
    bus.frame_tick = 1'b1;
    send_frame(8'h75, 1'b0);
    repeat (4) @(negedge vga_clk);
    bus.frame_tick = 1'b0;
    b2b_en = 0;
    b2b_arm = 0;
    @(negedge vga_clk);
    model_byte(8'h75);
    m_y = m_y - b2b_cnt;
    vectors++; if (kv_y !== 10'(y0)) begin miscompares++; $display("FAIL b2b_y_at_event: got %0d want %0d", kv_y, y0); end
    vectors++; if (b2b_cnt < 1) begin miscompares++; $display("FAIL b2b_ticks_after_event: got %0d want >=1", b2b_cnt); end
    vectors++; if (bus.sq_pos_y !== 10'(m_y)) begin miscompares++; $display("FAIL b2b_y: got %0d want %0d", bus.sq_pos_y, m_y); end
    vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL b2b_dir: got %b want %b", bus.dir, m_dir()); end
    vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL b2b_kv_count: got %0d want %0d", kv_cnt, m_ev); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
  endtask

  task automatic test_random();
    logic [7:0] arrows [4];
    logic [7:0] b;
    int r;
    arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h6B; arrows[3] = 8'h74;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 3) b = 8'hF0;
      else if (r < 7) b = arrows[$urandom_range(0, 3)];
      else            b = 8'($urandom_range(0, 255));
      send_byte(b);
      ticks($urandom_range(0, 3));
      vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL rnd_kv_count[%0d] byte %h: got %0d want %0d", i, b, kv_cnt, m_ev); end
      vectors++; if (bus.dir !== m_dir()) begin miscompares++; $display("FAIL rnd_dir[%0d] byte %h: got %b want %b", i, b, bus.dir, m_dir()); end
      vectors++; if (bus.sq_pos_x !== 10'(m_x)) begin miscompares++; $display("FAIL rnd_x[%0d]: got %0d want %0d", i, bus.sq_pos_x, m_x); end
      vectors++; if (bus.sq_pos_y !== 10'(m_y)) begin miscompares++; $display("FAIL rnd_y[%0d]: got %0d want %0d", i, bus.sq_pos_y, m_y); end
    end
  endtask

  task automatic test_limit_reset();
    reset_n = 1'b0;
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge vga_clk);
    send_byte(8'hE0);
    send_byte(8'h6B);
    ticks(400);
    vectors++; if (bus.sq_pos_x !== 10'd10) begin miscompares++; $display("FAIL lim_x: got %0d want 10", bus.sq_pos_x); end
    vectors++; if (bus.sq_pos_x !== 10'(m_x)) begin miscompares++; $display("FAIL lim_x_model: got %0d want %0d", bus.sq_pos_x, m_x); end
    vectors++; if (bus.dir !== 4'b0010) begin miscompares++; $display("FAIL lim_dir_kept: got %b want 0010", bus.dir); end
    drive_bit(1'b0);
    drive_bit(1'b1);
    bus.ps2_data = 1'b0;
    repeat (HB) @(negedge vga_clk);
    bus.ps2_clk = 1'b0;
    repeat (2) @(negedge vga_clk);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    vectors++; if (bus.sq_pos_x !== 10'd320) begin miscompares++; $display("FAIL rst_mid_x: got %0d want 320", bus.sq_pos_x); end
    vectors++; if (bus.sq_pos_y !== 10'd240) begin miscompares++; $display("FAIL rst_mid_y: got %0d want 240", bus.sq_pos_y); end
    vectors++; if (bus.dir !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_dir: got %b want 0000", bus.dir); end
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge vga_clk);
    send_byte(8'hE0);
    send_byte(8'h75);
    vectors++; if (kv_cnt !== m_ev) begin miscompares++; $display("FAIL post_rst_kv_count: got %0d want %0d", kv_cnt, m_ev); end
    vectors++; if (kv_code !== 8'h75) begin miscompares++; $display("FAIL post_rst_key_code: got %h want 75", kv_code); end
    vectors++; if (bus.dir !== 4'b1000) begin miscompares++; $display("FAIL post_rst_dir: got %b want 1000", bus.dir); end
  endtask

  initial begin
    bus.ps2_clk    = 1'b1;
    bus.ps2_data   = 1'b1;
    bus.frame_tick = 1'b0;
    model_reset();
    test_reset();
    test_up_make();
    test_reverse();
    test_left_break();
    test_parity_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_limit_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
